// File: rtl/program_loader.sv
// program_loader: boot-time writer for the CPU instruction memory.
// It receives a framed byte stream (0xA5, LEN, LEN big-endian words, CHK)
// over a valid/ready handshake and writes each word to consecutive
// addresses starting at 0. The CPU is held in reset until a frame
// arrives with a matching 8-bit checksum.
module program_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              start,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_HI, S_LO, S_CHK, S_DONE, S_ERR
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        sum_q, sum_d;
  logic [7:0]        hi_q, hi_d;
  logic [ADDR_W:0]   remaining_q, remaining_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              pend_q, pend_d;
  logic [15:0]       pend_data_q, pend_data_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [15:0]       imem_wdata_q, imem_wdata_d;
  logic [ADDR_W:0]   word_count_q, word_count_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              cpu_reset_q, cpu_reset_d;

  logic              accept;
  logic [ADDR_W:0]   len_words;

  // The loader only stops listening while it sits in DONE.
  assign in_ready = (state_q != S_DONE);
  assign accept   = in_valid && in_ready;

  // A LEN byte of zero stands for a full 2^ADDR_W-word frame.
  assign len_words = (in_data == 8'h00) ? ((ADDR_W+1)'(1) << ADDR_W)
                                        : (ADDR_W+1)'(in_data);

  // Next-state and next-output logic for the frame parser and write stage.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    state_d      = state_q;
    sum_d        = sum_q;
    hi_d         = hi_q;
    remaining_d  = remaining_q;
    addr_d       = addr_q;
    pend_d       = 1'b0;
    pend_data_d  = pend_data_q;
    imem_we_d    = pend_q;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    word_count_d = word_count_q;
    done_d       = done_q;
    error_d      = error_q;
    cpu_reset_d  = cpu_reset_q;

    // A word completed on the previous edge is written now, one cycle after
    // its low byte, so the address and data are presented from flops.
    if (pend_q) begin
      imem_addr_d  = addr_q;
      imem_wdata_d = pend_data_q;
      addr_d       = addr_q + ADDR_W'(1);
      word_count_d = word_count_q + (ADDR_W+1)'(1);
    end

    unique case (state_q)
      S_IDLE, S_ERR: begin
        if (accept && in_data == SYNC_BYTE) begin
          state_d      = S_LEN;
          sum_d        = 8'h00;
          addr_d       = '0;
          word_count_d = '0;
          error_d      = 1'b0;
        end
      end
      S_LEN: begin
        if (accept) begin
          remaining_d = len_words;
          state_d     = S_HI;
        end
      end
      S_HI: begin
        if (accept) begin
          hi_d    = in_data;
          sum_d   = sum_q + in_data;
          state_d = S_LO;
        end
      end
      S_LO: begin
        if (accept) begin
          sum_d       = sum_q + in_data;
          pend_d      = 1'b1;
          pend_data_d = {hi_q, in_data};
          remaining_d = remaining_q - (ADDR_W+1)'(1);
          state_d     = (remaining_q == (ADDR_W+1)'(1)) ? S_CHK : S_HI;
        end
      end
      S_CHK: begin
        if (accept) begin
          if (in_data == sum_q) begin
            state_d     = S_DONE;
            done_d      = 1'b1;
            cpu_reset_d = 1'b0;
          end else begin
            state_d     = S_ERR;
            error_d     = 1'b1;
            cpu_reset_d = 1'b1;
          end
        end
      end
      S_DONE: begin
        if (start) begin
          state_d     = S_IDLE;
          done_d      = 1'b0;
          cpu_reset_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset drops any half-assembled word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      sum_q        <= 8'h00;
      hi_q         <= 8'h00;
      remaining_q  <= '0;
      addr_q       <= '0;
      pend_q       <= 1'b0;
      pend_data_q  <= 16'h0000;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= 16'h0000;
      word_count_q <= '0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      cpu_reset_q  <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      sum_q        <= sum_d;
      hi_q         <= hi_d;
      remaining_q  <= remaining_d;
      addr_q       <= addr_d;
      pend_q       <= pend_d;
      pend_data_q  <= pend_data_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      word_count_q <= word_count_d;
      done_q       <= done_d;
      error_q      <= error_d;
      cpu_reset_q  <= cpu_reset_d;
    end
  end

  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign word_count = word_count_q;
  assign done       = done_q;
  assign error      = error_q;
  assign cpu_reset  = cpu_reset_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: a per-cycle vector table for one
// complete frame, then hand-written sequences for bad checksum, leading
// garbage, gapped delivery, a full 256-word frame and mid-frame reset.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        start;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [15:0] imem_wdata;
  logic        cpu_reset;
  logic        done;
  logic        error;
  logic [8:0]  word_count;

  int n_cmp = 0;
  int n_bad = 0;

  program_loader #(.ADDR_W(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .start      (start),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .done       (done),
    .error      (error),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  // Every write strobe seen mid-cycle is logged for later comparison.
  typedef struct { logic [7:0] a; logic [15:0] d; } wr_t;
  wr_t wq[$];
  always @(negedge clk) if (imem_we) wq.push_back('{imem_addr, imem_wdata});

  typedef struct {
    logic [7:0]  data;
    logic        valid;
    logic        we;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic        done;
    logic        err;
    logic        cpu;
    logic        rdy;
    logic [8:0]  wc;
  } vec_t;

  vec_t vec[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, wanted %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_gapped(input logic [7:0] b);
    repeat ($urandom_range(0, 2)) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      @(posedge clk);
      #1;
    end
    send(b);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic check_status(input string tag, input logic d, input logic e,
                              input logic c, input logic r);
    check({tag, ".done"}, 32'(done), 32'(d));
    check({tag, ".error"}, 32'(error), 32'(e));
    check({tag, ".cpu_reset"}, 32'(cpu_reset), 32'(c));
    check({tag, ".in_ready"}, 32'(in_ready), 32'(r));
  endtask

  task automatic check_write(input string tag, input int idx,
                             input logic [7:0] a, input logic [15:0] d);
    if (idx < wq.size()) begin
      check({tag, ".addr"}, 32'(wq[idx].a), 32'(a));
      check({tag, ".data"}, 32'(wq[idx].d), 32'(d));
    end else begin
      check({tag, ".missing"}, 32'(wq.size()), 32'(idx + 1));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".we"}, 32'(imem_we), 32'd0);
    check({tag, ".addr"}, 32'(imem_addr), 32'd0);
    check({tag, ".wdata"}, 32'(imem_wdata), 32'd0);
    check({tag, ".wc"}, 32'(word_count), 32'd0);
    check_status(tag, 1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  initial begin
    int bad_words;

    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    start    = 1'b0;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Frame A5 02 12 34 AB CD BE; 0x12+0x34+0xAB+0xCD = 0x1BE, so CHK=0xBE.
    vec[0] = '{8'hA5, 1'b1, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 9'd0};
    vec[1] = '{8'h02, 1'b1, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 9'd0};
    vec[2] = '{8'h12, 1'b1, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 9'd0};
    vec[3] = '{8'h34, 1'b1, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 9'd0};
    vec[4] = '{8'hAB, 1'b1, 1'b1, 8'h00, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b1, 9'd1};
    vec[5] = '{8'hCD, 1'b1, 1'b0, 8'h00, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b1, 9'd1};
    vec[6] = '{8'hBE, 1'b1, 1'b1, 8'h01, 16'hABCD, 1'b1, 1'b0, 1'b0, 1'b0, 9'd2};
    vec[7] = '{8'h00, 1'b0, 1'b0, 8'h01, 16'hABCD, 1'b1, 1'b0, 1'b0, 1'b0, 9'd2};

    for (int i = 0; i < 8; i++) begin
      string tag;
      tag      = $sformatf("vec%0d", i);
      in_data  = vec[i].data;
      in_valid = vec[i].valid;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check({tag, ".we"}, 32'(imem_we), 32'(vec[i].we));
      check({tag, ".addr"}, 32'(imem_addr), 32'(vec[i].addr));
      check({tag, ".wdata"}, 32'(imem_wdata), 32'(vec[i].wdata));
      check({tag, ".wc"}, 32'(word_count), 32'(vec[i].wc));
      check_status(tag, vec[i].done, vec[i].err, vec[i].cpu, vec[i].rdy);
    end

    // Bytes offered in DONE are refused and produce no write.
    wq.delete();
    send(8'hA5);
    idle(2);
    check("done_hold.writes", 32'(wq.size()), 32'd0);
    check_status("done_hold", 1'b1, 1'b0, 1'b0, 1'b0);

    // start re-arms the loader.
    pulse_start();
    check_status("start", 1'b0, 1'b0, 1'b1, 1'b1);

    // Same frame with a bad checksum: words land, then ERR.
    wq.delete();
    foreach (vec[i]) if (i < 6) send(vec[i].data);
    send(8'h6F);
    idle(1);
    check("bad.writes", 32'(wq.size()), 32'd2);
    check_write("bad.w0", 0, 8'h00, 16'h1234);
    check_write("bad.w1", 1, 8'h01, 16'hABCD);
    check_status("bad", 1'b0, 1'b1, 1'b1, 1'b1);
    check("bad.wc", 32'(word_count), 32'd2);

    // A good frame out of ERR clears error on the sync byte.
    send(8'hA5);
    check("recover.sync_error", 32'(error), 32'd0);
    check("recover.sync_wc", 32'(word_count), 32'd0);
    foreach (vec[i]) if (i >= 1 && i < 7) send(vec[i].data);
    idle(1);
    check_status("recover", 1'b1, 1'b0, 1'b0, 1'b0);

    // Leading garbage, then a 1-word frame A5 01 00 07 07.
    pulse_start();
    wq.delete();
    send(8'h00); send(8'hFF); send(8'h5A);
    check("garbage.writes", 32'(wq.size()), 32'd0);
    check("garbage.wc", 32'(word_count), 32'd2);
    send(8'hA5); send(8'h01); send(8'h00); send(8'h07); send(8'h07);
    idle(1);
    check("one.writes", 32'(wq.size()), 32'd1);
    check_write("one.w0", 0, 8'h00, 16'h0007);
    check("one.wc", 32'(word_count), 32'd1);
    check_status("one", 1'b1, 1'b0, 1'b0, 1'b0);

    // Gapped delivery of 0102 8081 FFEE; byte sum 0x2F1 -> CHK 0xF1.
    pulse_start();
    wq.delete();
    idle(3);
    check("gap.idle_writes", 32'(wq.size()), 32'd0);
    send_gapped(8'hA5); send_gapped(8'h03);
    send_gapped(8'h01); send_gapped(8'h02);
    send_gapped(8'h80); send_gapped(8'h81);
    send_gapped(8'hFF); send_gapped(8'hEE);
    send_gapped(8'hF1);
    idle(1);
    check("gap.writes", 32'(wq.size()), 32'd3);
    check_write("gap.w0", 0, 8'h00, 16'h0102);
    check_write("gap.w1", 1, 8'h01, 16'h8081);
    check_write("gap.w2", 2, 8'h02, 16'hFFEE);
    check("gap.wc", 32'(word_count), 32'd3);
    check_status("gap", 1'b1, 1'b0, 1'b0, 1'b0);

    // LEN=0: 256 words of value i; low bytes sum to 0x7F80 -> CHK 0x80.
    pulse_start();
    wq.delete();
    send(8'hA5);
    send(8'h00);
    for (int i = 0; i < 256; i++) begin
      send(8'h00);
      send(8'(i));
    end
    send(8'h80);
    idle(1);
    check("full.writes", 32'(wq.size()), 32'd256);
    bad_words = 0;
    foreach (wq[i])
      if (wq[i].a !== 8'(i) || wq[i].d !== 16'(i)) bad_words++;
    check("full.content_errors", 32'(bad_words), 32'd0);
    check("full.wc", 32'(word_count), 32'd256);
    check_status("full", 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset after the high byte of the second word: word 0 stays, word 1 never written.
    pulse_start();
    wq.delete();
    send(8'hA5); send(8'h02); send(8'h11); send(8'h22); send(8'h33);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    reset_n = 1'b1;
    idle(3);
    check("midreset.writes", 32'(wq.size()), 32'd1);
    check_write("midreset.w0", 0, 8'h00, 16'h1122);

    // Good load after reset, then start returns to IDLE with the CPU held.
    send(8'hA5); send(8'h01); send(8'h00); send(8'h07); send(8'h07);
    idle(1);
    check_status("after_reset", 1'b1, 1'b0, 1'b0, 1'b0);
    pulse_start();
    check_status("final_start", 1'b0, 1'b0, 1'b1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
